rst_sequencer: RTL and testbench
================================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 16: consecutive synchronized-lock cycles required before leaving WAIT_LOCK; legal range 1..2^24-1.
REQ-002 Parameter DDR_RST_CYCLES, default 200: cycles ddr2_if_rst_o is held in DDR_RST; legal range 1..2^24-1.
REQ-003 Parameter CALIB_TIMEOUT, default 1048576: maximum WAIT_CALIB dwell in cycles before FAULT; legal range 1..2^24-1.
REQ-004 Parameter WB_RST_CYCLES, default 16: cycles wb_rst_o is held after calibration completes; legal range 1..2^24-1.
REQ-005 wb_clk  input  1  sole clock; all state is on its rising edge.
REQ-006 rst_n_pad_i  input  1  reset, asynchronous assert, active-low.
REQ-007 locked_mcm  input  1  clock-manager lock, asynchronous to wb_clk.
REQ-008 ddr2_calib_done_i  input  1  DDR2 controller calibration complete, asynchronous to wb_clk.
REQ-009 wb_rst_o  output  1  Wishbone reset, active-high.
REQ-010 ddr2_if_rst_o  output  1  DDR2 interface reset, active-high.
REQ-011 seq_state_o  output  3  current state encoding.
REQ-012 calib_timeout_o  output  1  sticky calibration-timeout flag.

Function
REQ-013 locked_mcm and ddr2_calib_done_i SHALL each pass a 2-flop synchronizer (lock_s, calib_s) before any use; the synchronizer flops reset to 0.
REQ-014 States and encodings SHALL be: WAIT_LOCK=1, DDR_RST=2, WAIT_CALIB=3, WB_RST=4, RUN=5, FAULT=6; encodings 0 and 7 are unused and SHALL transition to WAIT_LOCK.
REQ-015 A single 24-bit cycle counter SHALL clear on every state entry and increment by 1 each cycle otherwise, saturating at all-ones.
REQ-016 WAIT_LOCK: the counter SHALL clear whenever lock_s=0; the FSM SHALL enter DDR_RST on the cycle the counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1.
REQ-017 DDR_RST: the FSM SHALL enter WAIT_CALIB after exactly DDR_RST_CYCLES cycles in this state.
REQ-018 WAIT_CALIB: calib_s=1 SHALL enter WB_RST; otherwise, on the counter reaching CALIB_TIMEOUT-1, the FSM SHALL enter FAULT; if both conditions hold in the same cycle, calib_s wins.
REQ-019 WB_RST: the FSM SHALL enter RUN after exactly WB_RST_CYCLES cycles in this state.
REQ-020 RUN: the FSM SHALL remain in RUN while lock_s=1 and calib_s=1; calib_s=0 SHALL enter DDR_RST.
REQ-021 FAULT: calib_timeout_o SHALL set; the FSM SHALL stay in FAULT one cycle, then enter DDR_RST (automatic retry, unlimited retries).
REQ-022 In any state other than WAIT_LOCK, lock_s=0 SHALL enter WAIT_LOCK next cycle, with priority over all other transitions.
REQ-023 Registered outputs: ddr2_if_rst_o=1 in WAIT_LOCK, DDR_RST and FAULT, otherwise 0; wb_rst_o=0 only in RUN; both outputs SHALL be registered, with no combinational path from inputs.
REQ-024 calib_timeout_o SHALL clear only on reset; re-entry to RUN SHALL NOT clear it.
REQ-025 seq_state_o SHALL equal the state register directly.

Reset
REQ-026 While rst_n_pad_i=0: state=WAIT_LOCK, counter=0, wb_rst_o=1, ddr2_if_rst_o=1, calib_timeout_o=0, synchronizers=0, all asynchronously.
REQ-027 Reset deassertion SHALL be synchronized internally; the first state update occurs on the second wb_clk edge after rst_n_pad_i rises.
REQ-028 Reset asserted mid-sequence SHALL return every register to its REQ-026 value immediately, regardless of state.

Verification (LOCK_STABLE_CYCLES=4, DDR_RST_CYCLES=8, CALIB_TIMEOUT=32, WB_RST_CYCLES=4)
REQ-029 Nominal bring-up: lock=1 at t0, calib=1 raised 10 cycles into WAIT_CALIB -> state walk 1,2,3,4,5; ddr2_if_rst_o falls on entry to WAIT_CALIB; wb_rst_o falls exactly 4 cycles after entry to WB_RST.
REQ-030 Lock glitch: lock high 3 cycles, low 1, high -> DDR_RST entered only after 4 further consecutive high cycles.
REQ-031 Timeout: calib held 0 -> FAULT after 32 cycles in WAIT_CALIB; calib_timeout_o=1; re-enters DDR_RST; later calib=1 -> reaches RUN with calib_timeout_o still 1.
REQ-032 Lock loss in RUN: lock drops -> both resets=1 and state=1 within 3 cycles of the drop (2 synchronizer + 1 register).
REQ-033 Calibration loss in RUN: calib drops -> state=2, ddr2_if_rst_o=1, wb_rst_o=1 for the full retry sequence.
REQ-034 Async reset mid-WB_RST: rst_n_pad_i=0 -> all outputs at reset values with no clock edge; after release, the sequence restarts from WAIT_LOCK.

Source files
------------

// File: rtl/rst_sequencer.sv
// Reset sequencer: brings up clock lock, DDR2 calibration and the Wishbone
// reset in order, retrying calibration after a timeout.
module rst_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 16,
    parameter int unsigned DDR_RST_CYCLES     = 200,
    parameter int unsigned CALIB_TIMEOUT      = 1048576,
    parameter int unsigned WB_RST_CYCLES      = 16
) (
    input  logic       wb_clk,
    input  logic       rst_n_pad_i,
    input  logic       locked_mcm,
    input  logic       ddr2_calib_done_i,
    output logic       wb_rst_o,
    output logic       ddr2_if_rst_o,
    output logic [2:0] seq_state_o,
    output logic       calib_timeout_o
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd1,
        ST_DDR_RST    = 3'd2,
        ST_WAIT_CALIB = 3'd3,
        ST_WB_RST     = 3'd4,
        ST_RUN        = 3'd5,
        ST_FAULT      = 3'd6
    } state_e;

    localparam logic [23:0] LOCK_LAST  = 24'(LOCK_STABLE_CYCLES - 1);
    localparam logic [23:0] DDR_LAST   = 24'(DDR_RST_CYCLES - 1);
    localparam logic [23:0] CALIB_LAST = 24'(CALIB_TIMEOUT - 1);
    localparam logic [23:0] WB_LAST    = 24'(WB_RST_CYCLES - 1);

    logic        en_q;
    logic [1:0]  lock_q;
    logic [1:0]  calib_q;
    logic        lock_s;
    logic        calib_s;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        wb_rst_q, wb_rst_d;
    logic        ddr_rst_q, ddr_rst_d;
    logic        timeout_q, timeout_d;

    assign lock_s  = lock_q[1];
    assign calib_s = calib_q[1];

    // State flops only start moving once this flop has seen rst_n high,
    // so a release close to an edge can never corrupt them.
    always_ff @(posedge wb_clk or negedge rst_n_pad_i) begin
        if (!rst_n_pad_i) begin
            en_q    <= 1'b0;
            lock_q  <= 2'b00;
            calib_q <= 2'b00;
        end else begin
            en_q    <= 1'b1;
            lock_q  <= {lock_q[0], locked_mcm};
            calib_q <= {calib_q[0], ddr2_calib_done_i};
        end
    end

    always_ff @(posedge wb_clk or negedge rst_n_pad_i) begin
        if (!rst_n_pad_i) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            wb_rst_q  <= 1'b1;
            ddr_rst_q <= 1'b1;
            timeout_q <= 1'b0;
        end else if (en_q) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_rst_q  <= wb_rst_d;
            ddr_rst_q <= ddr_rst_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s && cnt_q == LOCK_LAST) state_d = ST_DDR_RST;
            end
            ST_DDR_RST: begin
                if (cnt_q == DDR_LAST) state_d = ST_WAIT_CALIB;
            end
            ST_WAIT_CALIB: begin
                if (calib_s)                  state_d = ST_WB_RST;
                else if (cnt_q == CALIB_LAST) state_d = ST_FAULT;
            end
            ST_WB_RST: begin
                if (cnt_q == WB_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!calib_s) state_d = ST_DDR_RST;
            end
            ST_FAULT: state_d = ST_DDR_RST;
            default:  state_d = ST_WAIT_LOCK;
        endcase
        if (!lock_s) state_d = ST_WAIT_LOCK;

        if (state_d != state_q || (state_q == ST_WAIT_LOCK && !lock_s))
            cnt_d = '0;
        else if (cnt_q != '1)
            cnt_d = cnt_q + 24'd1;
        else
            cnt_d = cnt_q;

        // Outputs are decoded from the next state so they line up with it.
        ddr_rst_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_DDR_RST) ||
                    (state_d == ST_FAULT);
        wb_rst_d  = (state_d != ST_RUN);
        timeout_d = timeout_q || (state_d == ST_FAULT);
    end

    assign wb_rst_o        = wb_rst_q;
    assign ddr2_if_rst_o   = ddr_rst_q;
    assign seq_state_o     = state_q;
    assign calib_timeout_o = timeout_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: bring-up, lock glitch, calibration
// timeout and retry, lock/calibration loss and asynchronous reset.
module tb_rst_sequencer;

    localparam int S_WL = 1;
    localparam int S_DR = 2;
    localparam int S_WC = 3;
    localparam int S_WB = 4;
    localparam int S_RN = 5;
    localparam int S_FL = 6;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic       calib;
    logic       wb_rst;
    logic       ddr_rst;
    logic [2:0] state;
    logic       tmo;

    int n_chk;
    int n_err;
    int n;
    int bad;

    rst_sequencer #(
        .LOCK_STABLE_CYCLES(4),
        .DDR_RST_CYCLES    (8),
        .CALIB_TIMEOUT     (32),
        .WB_RST_CYCLES     (4)
    ) dut (
        .wb_clk           (clk),
        .rst_n_pad_i      (rst_n),
        .locked_mcm       (lock),
        .ddr2_calib_done_i(calib),
        .wb_rst_o         (wb_rst),
        .ddr2_if_rst_o    (ddr_rst),
        .seq_state_o      (state),
        .calib_timeout_o  (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input int s, input int budget, output int cnt);
        cnt = 0;
        while (int'(state) != s && cnt < budget) begin
            tick(1);
            cnt++;
        end
    endtask

    task automatic dwell(input int s, input int budget, output int cnt);
        cnt = 0;
        while (int'(state) == s && cnt < budget) begin
            tick(1);
            cnt++;
        end
    endtask

    task automatic chk_outs(input string tag, input int s, input int wb,
                            input int dd);
        chk({tag, "_state"}, 32'(state), s);
        chk({tag, "_wb"}, 32'(wb_rst), wb);
        chk({tag, "_ddr"}, 32'(ddr_rst), dd);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        lock  = 1'b1;
        calib = 1'b0;
        tick(3);
        chk_outs("rst", S_WL, 1, 1);
        chk("rst_tmo", 32'(tmo), 0);

        // Nominal bring-up
        rst_n = 1'b1;
        wait_state(S_DR, 20, n);
        chk("rel_to_ddr", n, 6);
        chk_outs("ddr_in", S_DR, 1, 1);
        dwell(S_DR, 20, n);
        chk("ddr_dwell", n, 8);
        chk_outs("wc_in", S_WC, 1, 0);
        tick(10);
        calib = 1'b1;
        wait_state(S_WB, 8, n);
        chk("calib_to_wb", n, 3);
        chk_outs("wb_in", S_WB, 1, 0);
        dwell(S_WB, 20, n);
        chk("wb_dwell", n, 4);
        chk_outs("run", S_RN, 0, 0);
        chk("run_tmo", 32'(tmo), 0);

        // Lock loss in RUN
        lock  = 1'b0;
        calib = 1'b0;
        tick(3);
        chk_outs("lock_loss", S_WL, 1, 1);

        // Lock glitch
        tick(4);
        lock = 1'b1;
        tick(3);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        chk("glitch_hold", 32'(state), S_WL);
        wait_state(S_DR, 20, n);
        chk("glitch_to_ddr", n, 6);

        // Calibration timeout and retry
        dwell(S_DR, 20, n);
        chk("tmo_ddr_dwell", n, 8);
        dwell(S_WC, 60, n);
        chk("wc_dwell", n, 32);
        chk_outs("fault", S_FL, 1, 1);
        chk("fault_tmo", 32'(tmo), 1);
        dwell(S_FL, 10, n);
        chk("fault_dwell", n, 1);
        chk("retry_state", 32'(state), S_DR);
        dwell(S_DR, 20, n);
        chk("retry_ddr_dwell", n, 8);
        calib = 1'b1;
        wait_state(S_RN, 20, n);
        chk("retry_run", 32'(state), S_RN);
        chk("retry_tmo", 32'(tmo), 1);

        // Calibration loss in RUN
        calib = 1'b0;
        tick(3);
        chk_outs("cal_loss", S_DR, 1, 1);
        bad = 0;
        n = 0;
        while (int'(state) != S_WB && n < 40) begin
            if (int'(state) == S_WC) calib = 1'b1;
            if (wb_rst == 1'b0) bad++;
            tick(1);
            n++;
        end
        chk("cal_loss_wb_low", bad, 0);
        chk("cal_loss_wb", 32'(state), S_WB);

        // Asynchronous reset mid-WB_RST
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async", S_WL, 1, 1);
        chk("async_tmo", 32'(tmo), 0);
        tick(2);
        rst_n = 1'b1;
        chk("restart_state", 32'(state), S_WL);
        wait_state(S_DR, 20, n);
        chk("restart_to_ddr", n, 6);
        wait_state(S_RN, 60, n);
        chk("restart_run", 32'(state), S_RN);
        chk("restart_wb", 32'(wb_rst), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
